// File: rtl/imem_loader.sv
// Instruction-memory loader: turns a UART byte stream (16-bit BE word count, then words MSB first)
// into 32-bit RAM writes. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  wr_en,
    output logic [31:0]           wr_addr,
    output logic [31:0]           wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_written
);

    localparam int unsigned CAPACITY = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHK,
        DONE,
        ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [31:0]         shift_q, shift_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0] words_q, words_d;
    logic                wr_en_q, wr_en_d;
    logic [31:0]         wr_addr_q, wr_addr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [15:0]         len_next;
    logic                last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    assign len_next  = {len_q[15:8], rx_data};
    // The final word's write strobe is still in flight; leave DATA only once it has been seen.
    assign last_word = wr_en_q && (32'(words_q) == 32'(len_q));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d    = LEN_HI;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    busy_d     = 1'b1;
                    words_d    = '0;
                    byte_cnt_d = '0;
                    wr_addr_d  = BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = 8'h00;
`endif
                end
            end
            LEN_HI: begin
                if (rx_valid) begin
                    len_d[15:8] = rx_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (rx_valid) begin
                    len_d[7:0] = rx_data;
                    if (len_next == 16'd0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (32'(len_next) > CAPACITY) begin
                        state_d = ERR;
                        busy_d  = 1'b0;
                        error_d = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (rx_valid) begin
                        busy_d = 1'b0;
                        if (rx_data == chk_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ERR;
                            error_d = 1'b1;
                        end
                    end else begin
                        state_d = CHK;
                    end
`else
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else if (rx_valid) begin
                    shift_d    = {shift_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d      = chk_q ^ rx_data;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = BASE_ADDR + 32'({words_q, 2'b00});
                        words_d   = words_q + 1'b1;
                    end
                end
            end
            CHK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (rx_valid) begin
                    busy_d = 1'b0;
                    if (rx_data == chk_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
`else
                state_d = IDLE;
                busy_d  = 1'b0;
`endif
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            words_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= BASE_ADDR;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = shift_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: drives byte streams and checks writes, status flags and counters.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_written;

    int checks   = 0;
    int failures = 0;

    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every RAM write away from the active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d);
        start    = s;
        rx_valid = v;
        rx_data  = d;
        tick();
        start    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, b);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        int          base;
        logic [7:0]  chk;
        logic [31:0] w;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tick();
        tick();
        checkOutput("rst_wr_en",   32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", wr_addr, 32'h0);
        checkOutput("rst_wr_data", wr_data, 32'h0);
        checkOutput("rst_busy",    32'(busy), 32'd0);
        checkOutput("rst_done",    32'(done), 32'd0);
        checkOutput("rst_error",   32'(error), 32'd0);
        checkOutput("rst_words",   32'(words_written), 32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] two-word image");
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        sendByte(8'h00);
        sendByte(8'h02);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t1_start_ignored", 32'(busy), 32'd1);
        sendByte(8'h3C);
        sendByte(8'h08);
        sendByte(8'h40);
        checkOutput("t1_no_early_wr", 32'(wr_en), 32'd0);
        sendByte(8'h00);
        checkOutput("t1_w0_en",    32'(wr_en), 32'd1);
        checkOutput("t1_w0_addr",  wr_addr, 32'h0);
        checkOutput("t1_w0_data",  wr_data, 32'h3C08_4000);
        checkOutput("t1_w0_count", 32'(words_written), 32'd1);
        sendByte(8'h8D);
        checkOutput("t1_wr_pulse", 32'(wr_en), 32'd0);
        sendByte(8'h09);
        sendByte(8'h00);
        sendByte(8'h20);
        checkOutput("t1_w1_en",   32'(wr_en), 32'd1);
        checkOutput("t1_w1_addr", wr_addr, 32'h4);
        checkOutput("t1_w1_data", wr_data, 32'h8D09_0020);
`ifdef IMEM_LOADER_CHECKSUM_EN
        tick();
        sendByte(8'hD0);
`else
        tick();
`endif
        checkOutput("t1_done",  32'(done), 32'd1);
        checkOutput("t1_busy0", 32'(busy), 32'd0);
        checkOutput("t1_words", 32'(words_written), 32'd2);
        checkOutput("t1_nlog",  32'(log_addr.size()), 32'd2);

        $display("[TB] empty image");
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t2_done_cleared", 32'(done), 32'd0);
        sendByte(8'h00);
        sendByte(8'h00);
        checkOutput("t2_done",  32'(done), 32'd1);
        checkOutput("t2_busy",  32'(busy), 32'd0);
        tick();
        checkOutput("t2_nowr",  32'(log_addr.size()), 32'(base));

        $display("[TB] oversize image then recovery");
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h01);
        sendByte(8'h01);
        checkOutput("t3_error", 32'(error), 32'd1);
        checkOutput("t3_busy",  32'(busy), 32'd0);
        checkOutput("t3_done",  32'(done), 32'd0);
        tick();
        checkOutput("t3_nowr",  32'(log_addr.size()), 32'(base));
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("t3_err_cleared", 32'(error), 32'd0);
        checkOutput("t3_busy_again",  32'(busy), 32'd1);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'hDE);
        sendByte(8'hAD);
        sendByte(8'hBE);
        sendByte(8'hEF);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h22);
`else
        tick();
`endif
        checkOutput("t3_done2", 32'(done), 32'd1);
        checkOutput("t3_addr",  log_addr[log_addr.size()-1], 32'h0);
        checkOutput("t3_data",  log_data[log_data.size()-1], 32'hDEAD_BEEF);

        $display("[TB] full-capacity back-to-back image");
        base = log_addr.size();
        chk  = 8'h00;
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h01);
        sendByte(8'h00);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i), 8'hA5, 8'(i) ^ 8'h5A};
            for (int b = 3; b >= 0; b--) begin
                sendByte(w[b*8 +: 8]);
                chk = chk ^ w[b*8 +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(chk);
`else
        tick();
`endif
        tick();
        checkOutput("t4_done",  32'(done), 32'd1);
        checkOutput("t4_words", 32'(words_written), 32'd256);
        checkOutput("t4_nlog",  32'(log_addr.size() - base), 32'd256);
        if (log_addr.size() - base == 256) begin
            for (int i = 0; i < 256; i++) begin
                checkOutput($sformatf("t4_addr%0d", i), log_addr[base+i], 32'(i * 4));
                checkOutput($sformatf("t4_data%0d", i), log_data[base+i],
                            {8'(i), ~8'(i), 8'hA5, 8'(i) ^ 8'h5A});
            end
            checkOutput("t4_last_addr", log_addr[base+255], 32'h3FC);
        end

        $display("[TB] reset mid-upload");
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h00);
        sendByte(8'h02);
        sendByte(8'h11);
        sendByte(8'h22);
        reset = 1'b1;
        #1;
        checkOutput("t5_busy",  32'(busy), 32'd0);
        checkOutput("t5_done",  32'(done), 32'd0);
        checkOutput("t5_words", 32'(words_written), 32'd0);
        checkOutput("t5_addr",  wr_addr, 32'h0);
        checkOutput("t5_data",  wr_data, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'hAA);
        sendByte(8'hBB);
        sendByte(8'hCC);
        sendByte(8'hDD);
`ifdef IMEM_LOADER_CHECKSUM_EN
        sendByte(8'h00);
`else
        tick();
`endif
        checkOutput("t5_nlog",    32'(log_addr.size() - base), 32'd1);
        checkOutput("t5_re_addr", log_addr[log_addr.size()-1], 32'h0);
        checkOutput("t5_re_data", log_data[log_data.size()-1], 32'hAABB_CCDD);
        checkOutput("t5_re_done", 32'(done), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum good and bad");
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h56);
        sendByte(8'h78);
        tick();
        sendByte(8'h08);
        checkOutput("t6_good_done",  32'(done), 32'd1);
        checkOutput("t6_good_error", 32'(error), 32'd0);
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 8'h00);
        sendByte(8'h00);
        sendByte(8'h01);
        sendByte(8'h12);
        sendByte(8'h34);
        sendByte(8'h56);
        sendByte(8'h78);
        sendByte(8'h09);
        checkOutput("t6_bad_error", 32'(error), 32'd1);
        checkOutput("t6_bad_done",  32'(done), 32'd0);
        checkOutput("t6_bad_nlog",  32'(log_addr.size() - base), 32'd1);
        checkOutput("t6_bad_addr",  log_addr[log_addr.size()-1], 32'h0);
        checkOutput("t6_bad_data",  log_data[log_data.size()-1], 32'h1234_5678);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
